// File: rtl/branch_redirect_ctrl.sv
// branch_redirect_ctrl: sequences ID-stage branch redirects to fetch, tracks delay slots, keeps branch stats
// Ports:
//   clk, rst (sync, active-low)
//   id_valid, id_stall, branch_flag, branch_addr, next_inst_delayslot_flag : ID-stage resolver inputs
//   if_ready : fetch accepts the redirect; flush : exception/ERET flush, abandons branch state
//   redirect_valid, redirect_pc : redirect request to fetch (pc is zero when not valid)
//   stall_req : ID stall while a redirect is held; id_in_delayslot : ID instruction is a delay slot
//   branch_cnt, taken_cnt : saturating counts of accepted control-flow / taken instructions
module branch_redirect_ctrl #(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic              id_stall,
    input  logic              branch_flag,
    input  logic [ADDR_W-1:0] branch_addr,
    input  logic              next_inst_delayslot_flag,
    input  logic              if_ready,
    input  logic              flush,
    output logic              redirect_valid,
    output logic [ADDR_W-1:0] redirect_pc,
    output logic              stall_req,
    output logic              id_in_delayslot,
    output logic [CNT_W-1:0]  branch_cnt,
    output logic [CNT_W-1:0]  taken_cnt
);
    typedef enum logic {IDLE, HOLD} state_t;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    state_t            state, state_nx;
    logic [ADDR_W-1:0] held_pc;
    logic              live, accept, park;
    // live masks every request during reset and during the flush cycle
    always_comb begin
        live           = rst & ~flush;
        stall_req      = live & (state == HOLD);
        accept         = live & id_valid & ~id_stall & ~stall_req;
        park           = accept & branch_flag & ~if_ready;
        redirect_valid = (state == HOLD) ? live : accept & branch_flag;
        redirect_pc    = !redirect_valid ? '0 : (state == HOLD) ? held_pc : branch_addr;
        state_nx       = flush ? IDLE : (state == HOLD) ? (if_ready ? IDLE : HOLD) : (park ? HOLD : IDLE);
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            state           <= IDLE;
            held_pc         <= '0;
            id_in_delayslot <= 1'b0;
            branch_cnt      <= '0;
            taken_cnt       <= '0;
        end else begin
            state <= state_nx;
            if (park)
                held_pc <= branch_addr;
            if (flush)
                id_in_delayslot <= 1'b0;
            else if (accept)
                id_in_delayslot <= next_inst_delayslot_flag;
            if (accept && next_inst_delayslot_flag && branch_cnt != CNT_MAX)
                branch_cnt <= branch_cnt + 1'b1;
            if (accept && branch_flag && taken_cnt != CNT_MAX)
                taken_cnt <= taken_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// tb_branch_redirect_ctrl: directed plus randomized checks of branch_redirect_ctrl against a behavioural model
module tb_branch_redirect_ctrl;
    localparam int ADDR_W = 32;
    localparam int CNT_W  = 4;
    localparam int SAT    = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst, id_valid, id_stall, branch_flag, next_inst_delayslot_flag, if_ready, flush;
    logic [ADDR_W-1:0] branch_addr;
    logic              redirect_valid, stall_req, id_in_delayslot;
    logic [ADDR_W-1:0] redirect_pc;
    logic [CNT_W-1:0]  branch_cnt, taken_cnt;

    int checks = 0;
    int errors = 0;

    // Model state: pending redirect, its target, delay-slot flag, statistics
    bit          m_pending;
    logic [31:0] m_target;
    bit          m_ds;
    int          m_branches, m_taken;

    branch_redirect_ctrl #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_stall(id_stall),
        .branch_flag(branch_flag), .branch_addr(branch_addr),
        .next_inst_delayslot_flag(next_inst_delayslot_flag), .if_ready(if_ready),
        .flush(flush), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .stall_req(stall_req), .id_in_delayslot(id_in_delayslot),
        .branch_cnt(branch_cnt), .taken_cnt(taken_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int sat_inc(input int v);
        return (v + 1 > SAT) ? SAT : v + 1;
    endfunction

    // One clock: drive inputs, check outputs mid-cycle, then advance the model at the edge
    task automatic step(input bit r, input bit v, input bit s, input bit bf,
                        input logic [31:0] addr, input bit ds, input bit rdy, input bit fl);
        bit          running, take;
        bit          e_rv, e_stall;
        logic [31:0] e_pc;
        rst = r; id_valid = v; id_stall = s; branch_flag = bf; branch_addr = addr;
        next_inst_delayslot_flag = ds; if_ready = rdy; flush = fl;
        running = r && !fl;
        take    = running && v && !s && !m_pending;
        if (m_pending) begin
            e_rv = running; e_stall = running; e_pc = running ? m_target : 32'h0;
        end else begin
            e_rv = take && bf; e_stall = 1'b0; e_pc = e_rv ? addr : 32'h0;
        end
        if (take && bf && !ds)
            $display("warning: taken branch without delay-slot flag at %0t", $time);
        #3;
        chk("redirect_valid", 64'(redirect_valid), 64'(e_rv));
        chk("redirect_pc", 64'(redirect_pc), 64'(e_pc));
        chk("stall_req", 64'(stall_req), 64'(e_stall));
        chk("id_in_delayslot", 64'(id_in_delayslot), 64'(m_ds));
        chk("branch_cnt", 64'(branch_cnt), 64'(m_branches));
        chk("taken_cnt", 64'(taken_cnt), 64'(m_taken));
        @(posedge clk);
        if (!r) begin
            m_pending = 0; m_target = 0; m_ds = 0; m_branches = 0; m_taken = 0;
        end else if (fl) begin
            m_pending = 0; m_ds = 0;
        end else if (m_pending) begin
            if (rdy) m_pending = 0;
        end else if (take) begin
            m_ds = ds;
            if (ds) m_branches = sat_inc(m_branches);
            if (bf) m_taken = sat_inc(m_taken);
            if (bf && !rdy) begin
                m_pending = 1; m_target = addr;
            end
        end
        #1;
    endtask

    task automatic idle();
        step(1, 0, 0, 0, 32'h0, 0, 1, 0);
    endtask

    initial begin
        rst = 0; id_valid = 0; id_stall = 0; branch_flag = 0; branch_addr = 0;
        next_inst_delayslot_flag = 0; if_ready = 0; flush = 0;
        m_pending = 0; m_target = 0; m_ds = 0; m_branches = 0; m_taken = 0;
        repeat (2) @(posedge clk);
        #1;
        step(0, 1, 0, 1, 32'hdead_beef, 1, 0, 0);
        // taken, fetch ready
        step(1, 1, 0, 1, 32'h0000_0040, 1, 1, 0);
        idle();
        // taken, fetch busy; new ID instructions during HOLD are ignored
        step(1, 1, 0, 1, 32'h8000_0100, 1, 0, 0);
        step(1, 1, 0, 1, 32'h0000_0bad, 1, 0, 0);
        step(1, 1, 0, 0, 32'h0, 1, 0, 0);
        step(1, 1, 0, 0, 32'h0, 0, 1, 0);
        idle();
        // not-taken branch then a plain instruction
        step(1, 1, 0, 0, 32'h0, 1, 1, 0);
        step(1, 1, 0, 0, 32'h0, 0, 1, 0);
        idle();
        // delay slot survives ID stalls
        step(1, 1, 0, 1, 32'h0000_0200, 1, 1, 0);
        step(1, 1, 1, 1, 32'h0000_0300, 1, 1, 0);
        step(1, 1, 1, 0, 32'h0, 0, 1, 0);
        step(1, 1, 0, 0, 32'h0, 0, 1, 0);
        idle();
        // flush in HOLD
        step(1, 1, 0, 1, 32'h1234_5678, 1, 0, 0);
        step(1, 0, 0, 0, 32'h0, 0, 0, 0);
        step(1, 1, 0, 1, 32'h0, 1, 0, 1);
        idle();
        // reset in HOLD
        step(1, 1, 0, 1, 32'h1234_5678, 1, 0, 0);
        step(0, 0, 0, 0, 32'h0, 0, 0, 0);
        idle();
        // saturation
        for (int i = 0; i < 17; i++)
            step(1, 1, 0, 1, 32'h1000 + 32'(i * 4), 1, 1, 0);
        idle();
        // illegal taken branch without delay slot: counted as taken only
        step(1, 1, 0, 1, 32'h0000_0500, 0, 1, 0);
        idle();
        // randomized traffic
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 19) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0,
                 $urandom_range(0, 2) == 0, $urandom, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 2) != 0, $urandom_range(0, 14) == 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
